// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM of the multicycle MIPS core.
// Sequences fetch/decode/execute/mem/writeback and drives all datapath enables.
// Ports: clk_i, reset_i (sync, active-high), opcode_i[5:0], zero_i, mem_ready_i in;
//        pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
//        reg_write_o, alu_src_a_o, alu_src_b_o[1:0], pc_source_o[1:0], alu_op_o[2:0],
//        illegal_op_o, instr_done_o, state_o[3:0] out.
module mips_multicycle_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o,
    output logic [2:0] alu_op_o,
    output logic       illegal_op_o,
    output logic       instr_done_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXE  = 4'd6,  ALUWB = 4'd7,
        BRANCH = 4'd8,  IMMEXE = 4'd9,  IMMWB  = 4'd10, JUMP  = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   ready;

    assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        pc_en_o      = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_source_o  = 2'b00;
        alu_op_o     = 3'b000;
        illegal_op_o = 1'b0;
        instr_done_o = 1'b0;
        state_o      = state_q;
        case (state_q)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = ready;
                pc_en_o     = ready;
                state_d     = ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed here speculatively into ALUOut
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000:            state_d = RTEXE;
                    6'b000100, 6'b000101: state_d = BRANCH;
                    6'b001000, 6'b001101: state_d = IMMEXE;
                    6'b000010:            state_d = JUMP;
                    default:              illegal_op_o = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                state_d    = ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            MEMWR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = ready;
                state_d      = ready ? FETCH : MEMWR;
            end
            RTEXE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 3'b001;
                pc_source_o  = 2'b01;
                // opcode[0] separates bne (1) from beq (0)
                pc_en_o      = opcode_i[0] ^ zero_i;
                instr_done_o = 1'b1;
            end
            IMMEXE: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (opcode_i == 6'b001101) ? 3'b100 : 3'b000;
                state_d     = IMMWB;
            end
            IMMWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            JUMP: begin
                pc_source_o  = 2'b10;
                pc_en_o      = 1'b1;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase
        if (reset_i) begin
            state_d      = FETCH;
            pc_en_o      = 1'b0;
            iord_o       = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            pc_source_o  = 2'b00;
            alu_op_o     = 3'b000;
            illegal_op_o = 1'b0;
            instr_done_o = 1'b0;
            state_o      = 4'd0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: scoreboard bench for the multicycle control FSM.
module tb_mips_multicycle_control;
    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b, pc_src;
        logic [2:0] alu_op;
        logic       illegal, done;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010,
                           BAD = 6'b111111;

    logic clk = 1'b0, reset, zero, mem_ready;
    logic [5:0] opcode;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
    logic illegal, done;
    logic [1:0] src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    vec_t got;
    vec_t sb[$];
    int tests = 0, fails = 0, cycle = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en), .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .reg_write_o(reg_write), .alu_src_a_o(src_a), .alu_src_b_o(src_b),
        .pc_source_o(pc_src), .alu_op_o(alu_op), .illegal_op_o(illegal),
        .instr_done_o(done), .state_o(state)
    );

    assign got = '{state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, src_a, src_b, pc_src, alu_op, illegal, done};

    // Hand-written table of the state-only outputs
    function automatic vec_t moore(input logic [3:0] s);
        vec_t v = '0;
        v.st = s;
        case (s)
            4'd0:  begin v.mem_read = 1; v.src_b = 2'b01; end
            4'd1:  v.src_b = 2'b11;
            4'd2:  begin v.src_a = 1; v.src_b = 2'b10; end
            4'd3:  begin v.mem_read = 1; v.iord = 1; end
            4'd4:  begin v.reg_write = 1; v.mem_to_reg = 1; end
            4'd5:  begin v.mem_write = 1; v.iord = 1; end
            4'd6:  begin v.src_a = 1; v.alu_op = 3'b010; end
            4'd7:  begin v.reg_write = 1; v.reg_dst = 1; end
            4'd8:  begin v.src_a = 1; v.alu_op = 3'b001; v.pc_src = 2'b01; end
            4'd9:  begin v.src_a = 1; v.src_b = 2'b10; end
            4'd10: v.reg_write = 1;
            4'd11: v.pc_src = 2'b10;
            default: ;
        endcase
        return v;
    endfunction

    // One cycle of stimulus; m = {pc_en, ir_write, illegal, done}, aop overrides alu_op when nonzero
    task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] es, input logic [3:0] m, input logic [2:0] aop = 3'b000);
        vec_t e;
        @(posedge clk);
        #1;
        reset = r; opcode = op; zero = z; mem_ready = rdy;
        e = moore(es);
        {e.pc_en, e.ir_write, e.illegal, e.done} = m;
        if (aop != 3'b000) e.alu_op = aop;
        if (r) e = '0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        cycle++;
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL cyc%0d outputs got=%h exp=%h (state got %0d exp %0d)",
                         cycle, got, e, got.st, e.st);
            end
            if ((mem_read && mem_write) || (reg_write && mem_write)) begin
                fails++;
                $display("FAIL cyc%0d strobe_excl got rd=%b wr=%b rw=%b", cycle, mem_read, mem_write, reg_write);
            end
        end
    end

    initial begin
        reset = 1; opcode = LW; zero = 0; mem_ready = 1;
        // 1: reset then lw, 5 cycles
        cyc(1, LW, 0, 1, 0, 4'b0000);
        cyc(1, LW, 0, 1, 0, 4'b0000);
        cyc(0, LW, 0, 1, 0, 4'b1100);
        cyc(0, LW, 0, 0, 1, 4'b0000);
        cyc(0, LW, 0, 1, 2, 4'b0000);
        cyc(0, LW, 0, 1, 3, 4'b0000);
        cyc(0, LW, 0, 0, 4, 4'b0001);
        // fetch wait state, then sw with 3 wait cycles in MEMWR
        cyc(0, SW, 0, 0, 0, 4'b0000);
        cyc(0, SW, 0, 1, 0, 4'b1100);
        cyc(0, SW, 0, 1, 1, 4'b0000);
        cyc(0, SW, 0, 1, 2, 4'b0000);
        cyc(0, SW, 0, 0, 5, 4'b0000);
        cyc(0, SW, 0, 0, 5, 4'b0000);
        cyc(0, SW, 0, 0, 5, 4'b0000);
        cyc(0, SW, 0, 1, 5, 4'b0001);
        // lw with one MEMRD wait state
        cyc(0, LW, 0, 1, 0, 4'b1100);
        cyc(0, LW, 0, 1, 1, 4'b0000);
        cyc(0, LW, 0, 1, 2, 4'b0000);
        cyc(0, LW, 0, 0, 3, 4'b0000);
        cyc(0, LW, 0, 1, 3, 4'b0000);
        cyc(0, LW, 0, 1, 4, 4'b0001);
        // 3: beq/bne both zero polarities
        cyc(0, BEQ, 1, 1, 0, 4'b1100);
        cyc(0, BEQ, 1, 1, 1, 4'b0000);
        cyc(0, BEQ, 1, 0, 8, 4'b1001);
        cyc(0, BEQ, 0, 1, 0, 4'b1100);
        cyc(0, BEQ, 0, 1, 1, 4'b0000);
        cyc(0, BEQ, 0, 1, 8, 4'b0001);
        cyc(0, BNE, 0, 1, 0, 4'b1100);
        cyc(0, BNE, 0, 1, 1, 4'b0000);
        cyc(0, BNE, 0, 1, 8, 4'b1001);
        cyc(0, BNE, 1, 1, 0, 4'b1100);
        cyc(0, BNE, 1, 1, 1, 4'b0000);
        cyc(0, BNE, 1, 1, 8, 4'b0001);
        // 4: R-type, ori, addi
        cyc(0, RT, 0, 1, 0, 4'b1100);
        cyc(0, RT, 0, 1, 1, 4'b0000);
        cyc(0, RT, 0, 0, 6, 4'b0000);
        cyc(0, RT, 0, 1, 7, 4'b0001);
        cyc(0, ORI, 0, 1, 0, 4'b1100);
        cyc(0, ORI, 0, 1, 1, 4'b0000);
        cyc(0, ORI, 0, 1, 9, 4'b0000, 3'b100);
        cyc(0, ORI, 0, 1, 10, 4'b0001);
        cyc(0, ADDI, 0, 1, 0, 4'b1100);
        cyc(0, ADDI, 0, 1, 1, 4'b0000);
        cyc(0, ADDI, 0, 1, 9, 4'b0000);
        cyc(0, ADDI, 0, 1, 10, 4'b0001);
        // jump
        cyc(0, J, 0, 1, 0, 4'b1100);
        cyc(0, J, 0, 1, 1, 4'b0000);
        cyc(0, J, 0, 1, 11, 4'b1001);
        // 5: illegal opcode
        cyc(0, BAD, 0, 1, 0, 4'b1100);
        cyc(0, BAD, 0, 1, 1, 4'b0010);
        cyc(0, BAD, 0, 0, 0, 4'b0000);
        // 6: reset while stalled in MEMWR
        cyc(0, SW, 0, 1, 0, 4'b1100);
        cyc(0, SW, 0, 1, 1, 4'b0000);
        cyc(0, SW, 0, 1, 2, 4'b0000);
        cyc(0, SW, 0, 0, 5, 4'b0000);
        cyc(1, SW, 0, 0, 0, 4'b0000);
        cyc(0, SW, 0, 0, 0, 4'b0000);
        cyc(0, SW, 0, 1, 0, 4'b1100);
        cyc(0, SW, 0, 1, 1, 4'b0000);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
